// File: rtl/fpu_uart_tx_seq.sv
// Serialises a 64-bit FPU result as eight UART frames, ch_0 first, steering the upstream byte mux.
// Optional even-parity bit (8E1) when FPU_UART_PARITY_EN is defined; default build is 8N1.
module fpu_uart_tx_seq #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic [2:0] select,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

`ifdef FPU_UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_DONE, S_PARITY
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
    } state_e;
`endif

    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [2:0]    select_q;
    logic          busy_q;
    logic          done_q;
    logic          tx_q;
    logic          tx_d;
    logic          bit_end;
`ifdef FPU_UART_PARITY_EN
    logic          parity_q;
`endif

    assign bit_end = (baud_q == BAUD_LAST);

    // Line level for the current state; registered into tx_q so the pin never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef FPU_UART_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            select_q <= 3'b111;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tx_q     <= 1'b1;
`ifdef FPU_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            tx_q   <= tx_d;
            done_q <= (state_q == S_DONE);
            busy_q <= (state_q != S_IDLE);
            baud_q <= bit_end ? '0 : baud_q + BW'(1);

            case (state_q)
                S_IDLE: begin
                    baud_q   <= '0;
                    select_q <= 3'b111;
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                // Mux output for select_q is valid here; capture it for shifting.
                S_LOAD: begin
                    baud_q  <= '0;
                    shift_q <= byte_in;
`ifdef FPU_UART_PARITY_EN
                    parity_q <= ^byte_in;
`endif
                    state_q <= S_START;
                end
                S_START: begin
                    if (bit_end) state_q <= S_DATA;
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef FPU_UART_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef FPU_UART_PARITY_EN
                S_PARITY: begin
                    if (bit_end) state_q <= S_STOP;
                end
`endif
                // Channel select only wraps back to ch_0 through DONE, never mid-word.
                S_STOP: begin
                    if (bit_end) begin
                        if (select_q == 3'b000) begin
                            select_q <= 3'b111;
                            state_q  <= S_DONE;
                        end else begin
                            select_q <= select_q - 3'd1;
                            state_q  <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    baud_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign select = select_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign tx     = tx_q;

endmodule

// File: tb/tb_fpu_uart_tx_seq.sv
// Scoreboard bench for fpu_uart_tx_seq at BAUD_DIV=4; honours FPU_UART_PARITY_EN for 8E1 frames.
module tb_fpu_uart_tx_seq;

    localparam int unsigned B = 4;
`ifdef FPU_UART_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FRAME    = 1 + NB * B;
    localparam int unsigned DONE_LAT = 8 * FRAME + 1;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] byte_in;
    logic [2:0] select;
    logic       busy;
    logic       done;
    logic       tx;

    logic [7:0] ch [8];
    logic [7:0] w  [8];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0, n0, f0, lim;

    logic [7:0] sb[$];
    int         frame_starts[$];
    int         done_cycles[$];
    int         busy_falls[$];
    logic [2:0] sel_log[$];

    fpu_uart_tx_seq #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .byte_in (byte_in),
        .select  (select),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte mux model: select 3'b111 is ch_0, 3'b000 is ch_7.
    assign byte_in = ch[~select];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_level(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef FPU_UART_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // UART decoder: pops the expected byte at each start bit and checks every bit period.
    logic       tx_prev   = 1'b1;
    logic       busy_prev = 1'b0;
    logic [2:0] sel_prev  = 3'b111;
    bit         in_frame  = 1'b0;
    bit         bit_ok    = 1'b1;
    int         k         = 0;
    logic [7:0] exp_byte  = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            tx_prev   = 1'b1;
            busy_prev = 1'b0;
            sel_prev  = 3'b111;
        end else begin
            if (!in_frame && tx_prev === 1'b1 && tx === 1'b0) begin
                in_frame = 1'b1;
                k        = 0;
                bit_ok   = 1'b1;
                frame_starts.push_back(cyc);
                chk("frame_expected", 32'(sb.size() > 0), 32'd1);
                exp_byte = (sb.size() > 0) ? sb.pop_front() : 8'h00;
            end
            if (in_frame) begin
                if (tx !== frame_level(exp_byte, k / B)) bit_ok = 1'b0;
                if (k % B == B - 1) begin
                    chk($sformatf("byte%02h_bit%0d", exp_byte, k / B), 32'(bit_ok), 32'd1);
                    bit_ok = 1'b1;
                end
                k++;
                if (k == NB * B) in_frame = 1'b0;
            end
            if (done === 1'b1) done_cycles.push_back(cyc);
            if (busy_prev === 1'b1 && busy === 1'b0) busy_falls.push_back(cyc);
            if (select !== sel_prev) begin
                sel_log.push_back(select);
                sel_prev = select;
            end
            tx_prev   = tx;
            busy_prev = busy;
        end
    end

    task automatic run_word(input logic [7:0] wv [8], output int ts);
        for (int i = 0; i < 8; i++) begin
            ch[i] = wv[i];
            sb.push_back(wv[i]);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ts = cyc;
    endtask

    task automatic wait_done(input int ts, input int nd, input string tag);
        int l = 0;
        while (done_cycles.size() == nd && l < int'(DONE_LAT) + 50) begin
            @(negedge clk);
            l++;
        end
        chk({tag, "_done_seen"}, 32'(done_cycles.size() > nd), 32'd1);
        if (done_cycles.size() > nd)
            chk({tag, "_done_lat"}, 32'(done_cycles[nd] - ts), 32'(DONE_LAT));
    endtask

    task automatic run_full(input logic [7:0] wv [8], input string tag, input bit check_bits);
        int ts, fs, ss, nd, bs;
        logic seq [11];
        fs = frame_starts.size();
        ss = sel_log.size();
        nd = done_cycles.size();
        bs = busy_falls.size();
        seq[0] = 0; seq[1] = 1; seq[2] = 0; seq[3] = 1; seq[4] = 0;
        seq[5] = 0; seq[6] = 1; seq[7] = 0; seq[8] = 1;
`ifdef FPU_UART_PARITY_EN
        seq[9] = 0;
`else
        seq[9] = 1;
`endif
        seq[10] = 1;
        run_word(wv, ts);
        if (check_bits) begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < int'(NB * B); i++) begin
                @(negedge clk);
                chk($sformatf("%s_tx%0d", tag, i), 32'(tx), 32'(seq[i / B]));
            end
        end
        wait_done(ts, nd, tag);
        repeat (4) @(negedge clk);
        chk({tag, "_frames"}, 32'(frame_starts.size() - fs), 32'd8);
        for (int i = 0; i < 8 && fs + i < frame_starts.size(); i++)
            chk($sformatf("%s_frame%0d_start", tag, i), 32'(frame_starts[fs + i] - ts),
                32'(2 + FRAME * i));
        chk({tag, "_sel_steps"}, 32'(sel_log.size() - ss), 32'd8);
        for (int i = 0; i < 8 && ss + i < sel_log.size(); i++)
            chk($sformatf("%s_sel%0d", tag, i), 32'(sel_log[ss + i]),
                32'((i < 7) ? 6 - i : 7));
        chk({tag, "_done_pulses"}, 32'(done_cycles.size() - nd), 32'd1);
        chk({tag, "_busy_falls"}, 32'(busy_falls.size() - bs), 32'd1);
        if (busy_falls.size() > bs)
            chk({tag, "_busy_fall_t"}, 32'(busy_falls[bs] - ts), 32'(DONE_LAT + 1));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) ch[i] = 8'h00;

        // Reset held with start asserted: outputs stay idle.
        rst = 1'b1; start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_select", 32'(select), 32'd7);
        end
        rst = 1'b0; start = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_no_frame", 32'(frame_starts.size()), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_tx", 32'(tx), 32'd1);

        for (int i = 0; i < 8; i++) w[i] = 8'((i + 1) * 17);
        run_full(w, "word", 1'b0);

        w[0] = 8'hA5;
        for (int i = 1; i < 8; i++) w[i] = 8'(8'h5A + i);
        run_full(w, "bitord", 1'b1);

        // start held high for the whole burst: exactly one word goes out.
        n0 = done_cycles.size();
        f0 = frame_starts.size();
        for (int i = 0; i < 8; i++) begin
            ch[i] = 8'(8'hC0 + 3 * i);
            sb.push_back(ch[i]);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        lim = 0;
        while (done !== 1'b1 && lim < int'(DONE_LAT) + 50) begin
            @(negedge clk);
            lim++;
        end
        start = 1'b0;
        chk("hold_done_lat", 32'(cyc - t0), 32'(DONE_LAT));
        repeat (3 * FRAME) @(negedge clk);
        chk("hold_frames", 32'(frame_starts.size() - f0), 32'd8);
        chk("hold_done_pulses", 32'(done_cycles.size() - n0), 32'd1);
        chk("hold_busy_idle", 32'(busy), 32'd0);
        chk("hold_sb_empty", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 8; i++) w[i] = 8'(8'h81 ^ (i << 4));
        run_full(w, "fresh", 1'b0);

        // Reset during DATA of the third byte.
        for (int i = 0; i < 8; i++) w[i] = 8'(8'h0F + 8'(i * 29));
        run_word(w, t0);
        n0 = done_cycles.size();
        lim = 0;
        while (select !== 3'b101 && lim < 4 * int'(FRAME)) begin
            @(negedge clk);
            lim++;
        end
        chk("mid_reach_byte3", 32'(select), 32'd5);
        repeat (1 + 3 * B) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_select", 32'(select), 32'd7);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cycles.size() - n0), 32'd0);
        chk("mid_rst_idle_tx", 32'(tx), 32'd1);

        for (int i = 0; i < 8; i++) w[i] = 8'(8'hF0 - 8'(i * 7));
        run_full(w, "postrst", 1'b0);

        w[0] = 8'h07;
        for (int i = 1; i < 8; i++) w[i] = 8'(8'h30 + i);
        run_full(w, "par07", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
